stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Single-clock run/mode controller for the stopwatch datapath. Generates one-cycle count-enable strobes with an operation code (inc 1, inc 60, dec 1) for the seconds counter, and owns pause/clear sequencing from debounced buttons. Also produces the 7-segment digit-scan select, decimal point and adjust-mode blink mask. All timing comes from clock-enable dividers on `clk`; no derived clocks are used.

## Interface

Parameters:
- `CLK_PER_SEC`, default 100000000: `clk` cycles per second. Must be a multiple of 4 and at least 4.
- `SCAN_DIV`, default 2000000: `clk` cycles per digit-scan step (50 Hz at 100 MHz). Must be at least 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `btn_pause`  in  1  debounced pause button, level.
- `btn_reset`  in  1  debounced clear button, level.
- `sw`  in  3  mode switches: `sw[1:0]` is the mode, `sw[2]` selects minutes when in adjust mode.
- `cnt_en`  out  1  one-cycle count strobe to the seconds datapath.
- `cnt_op`  out  2  operation, valid when `cnt_en`=1: 00 = +1, 01 = +60, 10 = −1.
- `cnt_clr`  out  1  one-cycle clear strobe to the seconds datapath.
- `paused`  out  1  1 = counting halted.
- `dig_sel`  out  2  digit currently scanned (0 = seconds units … 3 = minutes tens).
- `dp`  out  1  decimal point for the current digit.
- `an_mask`  out  4  per-digit blank request; 1 = force anode off.

## Operation

- **Modes**
  - 00 = run up.
  - 01 = adjust: +60 if `sw[2]`, else +1.
  - 10 and 11 = countdown (−1).
- **Period**: `PER` = `CLK_PER_SEC` in modes 00, 10 and 11; `CLK_PER_SEC/2` in mode 01.
- **Run FSM**: states RUN and PAUSED; reset state is RUN. `paused` = (state == PAUSED).
  - A rising edge on `btn_pause` toggles between RUN and PAUSED.
  - Edge detection uses a registered copy of each button; that register resets to 0.
  - A button held high at reset release does not count as an edge.
- **Phase counter** `ph`:
  - In RUN it counts 0..`PER`−1 and wraps.
  - In PAUSED it holds its value.
  - When `ph` == `PER`−1 in RUN, the next cycle asserts `cnt_en`=1 with `cnt_op` decoded from the current `sw`.
- **Mode change**: any change of `sw[1:0]` (compared against a registered copy) sets `ph`=0 in the following cycle. No strobe is issued that cycle.
- **Clear**: a rising edge on `btn_reset` does three things.
  - Asserts `cnt_clr` for exactly one cycle.
  - Sets `ph`=0.
  - Leaves the FSM state unchanged.
- **Simultaneous events**
  - Clear and pause edges in the same cycle: clear wins and the pause edge is dropped.
  - Clear coinciding with a tick: the tick is suppressed, so `cnt_en` is never high with `cnt_clr`.
- **Scan**: the scan counter counts 0..`SCAN_DIV`−1. On wrap, `dig_sel` increments modulo 4. `dp` = 1 iff `dig_sel` == 2, and both are registered together.
- **Blink**: `blink_ph` toggles every `CLK_PER_SEC/4` cycles and runs regardless of pause. `an_mask` is:
  - 1100 when mode == 01 and `blink_ph`=1 and `sw[2]`=1.
  - 0011 when mode == 01 and `blink_ph`=1 and `sw[2]`=0.
  - 0000 otherwise.
- **Reset values**: all outputs 0, state RUN, and `ph`, the scan counter, the blink counter and `blink_ph` all 0.

## Timing

- All outputs are registered.
- `btn_pause` rises in cycle N → `paused` changes in cycle N+1.
- `btn_reset` rises in cycle N → `cnt_clr`=1 in cycle N+1 only, and `ph`=0 in cycle N+1.
- `rst` deasserted before cycle 0 → `ph`=0 in cycle 0, and the first `cnt_en` occurs in cycle `PER`. Strobes then repeat every `PER` cycles with no jitter.
- Resume from PAUSED:
  - The strobe arrives after the remaining `PER`−1−`ph` cycles plus 1.
  - Total RUN cycles between strobes is always `PER`.
- `rst` mid-period overrides everything in the same edge. There are no partial strobes after `rst`.
- `cnt_en` and `cnt_clr` are never high for more than one consecutive cycle.

## Test plan

All scenarios use `CLK_PER_SEC`=8 and `SCAN_DIV`=2.

1. **Reset/run**: `sw`=000, release `rst` → all outputs 0 in cycle 0; `cnt_en`=1 with `cnt_op`=00 in cycles 8, 16, 24 only.
2. **Adjust minutes**: `sw`=101 → `cnt_en` every 4 cycles with `cnt_op`=01; `an_mask` alternates 0000/1100 every 2 cycles. With `sw`=001 it alternates 0000/0011 and `cnt_op`=00.
3. **Pause**:
   - Pulse `btn_pause` while `ph`=3 → `paused`=1 next cycle and no `cnt_en` for 40 cycles.
   - A second pulse gives `paused`=0, then `cnt_en` after exactly 5 RUN cycles.
   - Holding the button high gives a single toggle.
4. **Clear**:
   - A `btn_reset` edge gives one `cnt_clr` pulse, and the next `cnt_en` comes 8 cycles later.
   - A `btn_reset` edge in the same cycle as a `btn_pause` edge leaves `paused` unchanged.
   - A `btn_reset` edge aligned to a tick produces no `cnt_en`.
5. **Mode change / countdown**: switch `sw` from 000 to 010 at `ph`=6 → no strobe at the old boundary; `cnt_en` with `cnt_op`=10 exactly 9 cycles after the change.
6. **Scan**: `dig_sel` cycles 0,1,2,3,0, each value held 2 cycles; `dp`=1 only while `dig_sel`=2; the scan is unaffected by pause and `btn_reset`.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button/switch inputs and strobe/display outputs of the stopwatch controller
interface stopwatch_if;
    logic       btn_pause;
    logic       btn_reset;
    logic [2:0] sw;
    logic       cnt_en;
    logic [1:0] cnt_op;
    logic       cnt_clr;
    logic       paused;
    logic [1:0] dig_sel;
    logic       dp;
    logic [3:0] an_mask;

    modport master (
        input  btn_pause, btn_reset, sw,
        output cnt_en, cnt_op, cnt_clr, paused, dig_sel, dp, an_mask
    );

    modport slave (
        output btn_pause, btn_reset, sw,
        input  cnt_en, cnt_op, cnt_clr, paused, dig_sel, dp, an_mask
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/clear sequencing, count strobes, digit scan and adjust blink
module stopwatch_ctrl #(
    parameter int CLK_PER_SEC = 100000000,
    parameter int SCAN_DIV    = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    stopwatch_if.master  bus
);
    localparam int PH_W   = $clog2(CLK_PER_SEC);
    localparam int SC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BL_DIV = CLK_PER_SEC / 4;
    localparam int BL_W   = (BL_DIV > 1) ? $clog2(BL_DIV) : 1;

    localparam logic [PH_W-1:0] PER_FULL_M1 = PH_W'(CLK_PER_SEC - 1);
    localparam logic [PH_W-1:0] PER_HALF_M1 = PH_W'(CLK_PER_SEC / 2 - 1);
    localparam logic [SC_W-1:0] SCAN_M1     = SC_W'(SCAN_DIV - 1);
    localparam logic [BL_W-1:0] BLINK_M1    = BL_W'(BL_DIV - 1);

    typedef enum logic {S_RUN = 1'b0, S_PAUSED = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            btn_pause_q, btn_reset_q, armed_q;
    logic [1:0]      mode_q;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [SC_W-1:0] scan_q, scan_d;
    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_ph_q, blink_ph_d;
    logic            cnt_en_q, cnt_en_d;
    logic [1:0]      cnt_op_q, cnt_op_d;
    logic            cnt_clr_q, cnt_clr_d;
    logic [1:0]      dig_sel_q, dig_sel_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_mask_q, an_mask_d;

    logic            pause_edge, clr_edge, mode_chg, tick, scan_wrap, blink_wrap;
    logic [PH_W-1:0] per_m1;
    logic [1:0]      op_now;

    // armed_q masks the first cycle after reset so a button held through reset is not an edge
    assign pause_edge = armed_q & bus.btn_pause & ~btn_pause_q;
    assign clr_edge   = armed_q & bus.btn_reset & ~btn_reset_q;
    assign mode_chg   = (bus.sw[1:0] != mode_q);
    assign per_m1     = (mode_q == 2'b01) ? PER_HALF_M1 : PER_FULL_M1;
    assign tick       = (state_q == S_RUN) && (ph_q == per_m1) && !clr_edge && !mode_chg;
    assign scan_wrap  = (scan_q == SCAN_M1);
    assign blink_wrap = (blink_cnt_q == BLINK_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            btn_pause_q <= 1'b0;
            btn_reset_q <= 1'b0;
            armed_q     <= 1'b0;
            mode_q      <= bus.sw[1:0];
            ph_q        <= '0;
            scan_q      <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            cnt_en_q    <= 1'b0;
            cnt_op_q    <= 2'b00;
            cnt_clr_q   <= 1'b0;
            dig_sel_q   <= 2'd0;
            dp_q        <= 1'b0;
            an_mask_q   <= 4'b0000;
        end else begin
            state_q     <= state_d;
            btn_pause_q <= bus.btn_pause;
            btn_reset_q <= bus.btn_reset;
            armed_q     <= 1'b1;
            mode_q      <= bus.sw[1:0];
            ph_q        <= ph_d;
            scan_q      <= scan_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            cnt_en_q    <= cnt_en_d;
            cnt_op_q    <= cnt_op_d;
            cnt_clr_q   <= cnt_clr_d;
            dig_sel_q   <= dig_sel_d;
            dp_q        <= dp_d;
            an_mask_q   <= an_mask_d;
        end
    end

    // a clear in the same cycle swallows the pause edge
    always_comb begin
        state_d = state_q;
        if (pause_edge && !clr_edge) begin
            state_d = (state_q == S_RUN) ? S_PAUSED : S_RUN;
        end
    end

    always_comb begin
        ph_d = ph_q;
        if (clr_edge || mode_chg) begin
            ph_d = '0;
        end else if (state_q == S_RUN) begin
            ph_d = (ph_q >= per_m1) ? '0 : ph_q + 1'b1;
        end

        case (bus.sw[1:0])
            2'b00:   op_now = 2'b00;
            2'b01:   op_now = {1'b0, bus.sw[2]};
            default: op_now = 2'b10;
        endcase
        cnt_en_d  = tick;
        cnt_op_d  = tick ? op_now : 2'b00;
        cnt_clr_d = clr_edge;

        scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
        dig_sel_d = scan_wrap ? dig_sel_q + 2'd1 : dig_sel_q;
        dp_d      = (dig_sel_d == 2'd2);

        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_ph_d  = blink_wrap ? ~blink_ph_q : blink_ph_q;
        an_mask_d   = 4'b0000;
        if (bus.sw[1:0] == 2'b01 && blink_ph_d) begin
            an_mask_d = bus.sw[2] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        bus.paused  = (state_q == S_PAUSED);
        bus.cnt_en  = cnt_en_q;
        bus.cnt_op  = cnt_op_q;
        bus.cnt_clr = cnt_clr_q;
        bus.dig_sel = dig_sel_q;
        bus.dp      = dp_q;
        bus.an_mask = an_mask_q;
    end
endmodule
